// File: rtl/exec_ctrl_pkg.sv
// Shared Y86 execute-control definitions: instruction/function codes,
// register and status codes, controller state encodings and the CC layout.
package exec_ctrl_pkg;

    // Instruction codes (icode)
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPL   = 4'hB;

    // ALU function codes (ifun for OPL)
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    // Branch/move condition codes (ifun for JXX/CMOVXX)
    localparam logic [3:0] C_YES    = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    // Register id meaning "no register"
    localparam logic [3:0] RNONE    = 4'hF;

    // Pipeline status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Controller state encodings
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Condition-code register, packed as {ZF,SF,OF}
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/exec_ctrl_cond_eval.sv
// Combinational jump/cmov condition evaluator.
// Ports:
//   cc_i   - condition codes {ZF,SF,OF}
//   ifun_i - condition selector (ifun of JXX/CMOVXX)
//   cnd_o  - condition result; 0 for undefined selectors
module exec_ctrl_cond_eval
    import exec_ctrl_pkg::*;
(
    input  cc_t        cc_i,
    input  logic [3:0] ifun_i,
    output logic       cnd_o
);

    logic lt;

    assign lt = cc_i.sf ^ cc_i.of;

    // Y86 condition table
    always_comb begin
        cnd_o = 1'b0;
        case (ifun_i)
            C_YES:   cnd_o = 1'b1;
            C_LE:    cnd_o = lt | cc_i.zf;
            C_L:     cnd_o = lt;
            C_E:     cnd_o = cc_i.zf;
            C_NE:    cnd_o = ~cc_i.zf;
            C_GE:    cnd_o = ~lt;
            C_G:     cnd_o = ~lt & ~cc_i.zf;
            default: cnd_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage pipeline controller for the Y86 core.
// Owns the condition-code register, evaluates e_Cnd, detects load-use /
// ret / mispredict hazards, drives stage stall/bubble controls, runs the
// RUN/DRAIN/HALTED state machine and keeps saturating perf counters.
// Ports:
//   clk, rst                 - clock, async active-low reset
//   D_icode, d_srcA, d_srcB  - decode-stage icode and source registers
//   E_icode, E_ifun, E_dstM  - execute-stage icode/ifun/load destination
//   e_valA, e_valB, e_valE   - ALU operands and result
//   M_icode, m_stat, W_stat  - memory icode, memory and writeback status
//   e_Cnd, cc_o              - condition result, CC register {ZF,SF,OF}
//   F_stall .. W_stall       - per-stage pipeline controls
//   cpu_halted, halt_stat    - halted flag and the status that caused it
//   perf_cycles/stalls/mispred - saturating performance counters
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_ifun,
    input  logic [3:0]        E_dstM,
    input  logic [WORD_W-1:0] e_valA,
    input  logic [WORD_W-1:0] e_valB,
    input  logic [WORD_W-1:0] e_valE,
    input  logic [3:0]        M_icode,
    input  logic [2:0]        m_stat,
    input  logic [2:0]        W_stat,
    output logic              e_Cnd,
    output logic [2:0]        cc_o,
    output logic              F_stall,
    output logic              D_stall,
    output logic              D_bubble,
    output logic              E_bubble,
    output logic              M_bubble,
    output logic              W_stall,
    output logic              cpu_halted,
    output logic [2:0]        halt_stat,
    output logic [CNT_W-1:0]  perf_cycles,
    output logic [CNT_W-1:0]  perf_stalls,
    output logic [CNT_W-1:0]  perf_mispred
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    cc_t              cc_q, cc_d;
    logic [1:0]       state_q, state_d;
    logic [2:0]       halt_stat_q, halt_stat_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] stl_q, stl_d;
    logic [CNT_W-1:0] mis_q, mis_d;

    logic cnd_raw;
    logic load_use;
    logic ret_haz;
    logic mispred;
    logic m_ok;
    logic w_ok;
    logic cc_we;
    logic sign_a;
    logic sign_b;
    logic sign_e;
    logic unused_val_lsbs;

    // Only operand sign bits matter for overflow detection
    assign sign_a          = e_valA[WORD_W-1];
    assign sign_b          = e_valB[WORD_W-1];
    assign sign_e          = e_valE[WORD_W-1];
    assign unused_val_lsbs = ^{e_valA[WORD_W-2:0], e_valB[WORD_W-2:0]};

    // Condition always comes from the registered CC, never the pending update
    exec_ctrl_cond_eval u_cond_eval (
        .cc_i   (cc_q),
        .ifun_i (E_ifun),
        .cnd_o  (cnd_raw)
    );

    assign e_Cnd = ((E_icode == I_JXX) || (E_icode == I_CMOVXX)) && cnd_raw;

    // Hazard detection
    assign m_ok     = (m_stat == STAT_AOK);
    assign w_ok     = (W_stat == STAT_AOK);
    assign load_use = ((E_icode == I_MRMOVL) || (E_icode == I_POPL)) &&
                      (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_haz  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred  = (E_icode == I_JXX) && !e_Cnd;

    // FSM next state and pipeline controls
    always_comb begin
        state_d     = state_q;
        halt_stat_d = halt_stat_q;
        F_stall     = 1'b0;
        D_stall     = 1'b0;
        D_bubble    = 1'b0;
        E_bubble    = 1'b0;
        M_bubble    = 1'b0;
        W_stall     = 1'b0;
        case (state_q)
            ST_RUN, ST_DRAIN: begin
                F_stall  = load_use | ret_haz;
                D_stall  = load_use;
                D_bubble = mispred | (ret_haz & ~load_use);
                E_bubble = mispred | load_use;
                M_bubble = ~m_ok | ~w_ok;
                W_stall  = ~w_ok;
                // Writeback fault wins over a memory fault in the same cycle
                if (!w_ok) begin
                    state_d     = ST_HALTED;
                    halt_stat_d = W_stat;
                end else if (!m_ok && (state_q == ST_RUN)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                W_stall = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign cc_we = (E_icode == I_OPL) && m_ok && w_ok && (state_q == ST_RUN);

    // Condition-code update from the ALU result
    always_comb begin
        cc_d = cc_q;
        if (cc_we) begin
            cc_d.zf = (e_valE == '0);
            cc_d.sf = sign_e;
            case (E_ifun)
                ALU_ADD: cc_d.of = (sign_a == sign_b) && (sign_e != sign_a);
                ALU_SUB: cc_d.of = (sign_a != sign_b) && (sign_e != sign_b);
                ALU_AND: cc_d.of = 1'b0;
                ALU_XOR: cc_d.of = 1'b0;
                default: cc_d.of = 1'b0;
            endcase
        end
    end

    // Saturating performance counters
    always_comb begin
        cyc_d = cyc_q;
        stl_d = stl_q;
        mis_d = mis_q;
        if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
            if (cyc_q != CNT_MAX) cyc_d = cyc_q + CNT_W'(1);
        end
        if (state_q == ST_RUN) begin
            if (F_stall && (stl_q != CNT_MAX)) stl_d = stl_q + CNT_W'(1);
            if (mispred && (mis_q != CNT_MAX)) mis_d = mis_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            halt_stat_q <= STAT_AOK;
            cc_q        <= CC_RESET;
            cyc_q       <= '0;
            stl_q       <= '0;
            mis_q       <= '0;
        end else begin
            state_q     <= state_d;
            halt_stat_q <= halt_stat_d;
            cc_q        <= cc_d;
            cyc_q       <= cyc_d;
            stl_q       <= stl_d;
            mis_q       <= mis_d;
        end
    end

    assign cc_o         = cc_q;
    assign cpu_halted   = (state_q == ST_HALTED);
    assign halt_stat    = halt_stat_q;
    assign perf_cycles  = cyc_q;
    assign perf_stalls  = stl_q;
    assign perf_mispred = mis_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl (CNT_W=4 so saturation is reachable).
// The driver sets inputs on the falling edge and queues hand-computed
// expectations; the monitor pops one entry per cycle shortly after.
module tb_exec_ctrl;
    import exec_ctrl_pkg::*;

    localparam int unsigned WW = 32;
    localparam int unsigned CW = 4;
    localparam int S_RUN = 0;
    localparam int S_DRN = 1;
    localparam int S_HLT = 2;
    localparam int S_RST = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_dstM, M_icode;
    logic [WW-1:0] e_valA, e_valB, e_valE;
    logic [2:0]    m_stat, W_stat;
    logic          e_Cnd, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, cpu_halted;
    logic [2:0]    cc_o, halt_stat;
    logic [CW-1:0] perf_cycles, perf_stalls, perf_mispred;

    typedef struct {
        string      nm;
        int         st;
        logic       cnd;
        logic [2:0] cc;
        logic [5:0] ctl;
        logic [2:0] hs;
        int         cyc;
        int         stl;
        int         mis;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         tot_cyc = 0, tot_stl = 0, tot_mis = 0;
    logic [2:0] exp_hs = STAT_AOK;

    exec_ctrl #(.WORD_W(WW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_dstM(E_dstM),
        .e_valA(e_valA), .e_valB(e_valB), .e_valE(e_valE),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .e_Cnd(e_Cnd), .cc_o(cc_o),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .cpu_halted(cpu_halted), .halt_stat(halt_stat),
        .perf_cycles(perf_cycles), .perf_stalls(perf_stalls), .perf_mispred(perf_mispred)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic nop();
        D_icode = I_NOP; d_srcA = RNONE; d_srcB = RNONE;
        E_icode = I_NOP; E_ifun = 4'h0; E_dstM = RNONE;
        e_valA = '0; e_valB = '0; e_valE = '0;
        M_icode = I_NOP; m_stat = STAT_AOK; W_stat = STAT_AOK;
    endtask

    task automatic ex(input logic [3:0] ic, input logic [3:0] fn);
        E_icode = ic; E_ifun = fn;
    endtask

    task automatic alu(input logic [3:0] fn, input logic [WW-1:0] a, input logic [WW-1:0] b,
                       input logic [WW-1:0] e);
        E_icode = I_OPL; E_ifun = fn; e_valA = a; e_valB = b; e_valE = e;
    endtask

    // ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    task automatic apply(input string nm, input int st, input logic cnd, input logic [2:0] cc,
                         input logic [5:0] ctl, input bit mp);
        exp_t e;
        e.nm = nm; e.st = st; e.cnd = cnd; e.cc = cc; e.ctl = ctl; e.hs = exp_hs;
        e.cyc = sat(tot_cyc); e.stl = sat(tot_stl); e.mis = sat(tot_mis);
        sb.push_back(e);
        if (st == S_RUN || st == S_DRN) tot_cyc++;
        if (st == S_RUN && ctl[5]) tot_stl++;
        if (st == S_RUN && mp) tot_mis++;
    endtask

    task automatic chk(input string nm, input string f, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s.%s got %0h want %0h", nm, f, got, want);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                chk(e.nm, "e_Cnd", 32'(e_Cnd), 32'(e.cnd));
                chk(e.nm, "cc", 32'(cc_o), 32'(e.cc));
                chk(e.nm, "ctl", 32'({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}),
                    32'(e.ctl));
                chk(e.nm, "halted", 32'(cpu_halted), 32'(e.st == S_HLT));
                chk(e.nm, "halt_stat", 32'(halt_stat), 32'(e.hs));
                chk(e.nm, "perf_cycles", 32'(perf_cycles), 32'(e.cyc));
                chk(e.nm, "perf_stalls", 32'(perf_stalls), 32'(e.stl));
                chk(e.nm, "perf_mispred", 32'(perf_mispred), 32'(e.mis));
            end
        end
    end

    // Driver
    initial begin
        rst = 1'b0;
        nop();
        @(negedge clk); apply("reset", S_RST, 1'b0, 3'b100, 6'b000000, 0);
        @(negedge clk); rst = 1'b1; nop(); ex(I_JXX, C_YES);
        apply("jmp", S_RUN, 1'b1, 3'b100, 6'b000000, 0);
        @(negedge clk); nop(); ex(I_JXX, C_E);    apply("je_z", S_RUN, 1'b1, 3'b100, 6'b000000, 0);
        @(negedge clk); nop(); ex(I_CMOVXX, C_NE); apply("cmovne", S_RUN, 1'b0, 3'b100, 6'b000000, 0);
        @(negedge clk); nop(); ex(I_CMOVXX, C_E);  apply("cmove", S_RUN, 1'b1, 3'b100, 6'b000000, 0);
        @(negedge clk); nop();                     apply("nop_cnd", S_RUN, 1'b0, 3'b100, 6'b000000, 0);
        @(negedge clk); nop(); alu(ALU_SUB, 32'd1, 32'd1, 32'd0);
        apply("subl_zero", S_RUN, 1'b0, 3'b100, 6'b000000, 0);
        @(negedge clk); nop(); alu(ALU_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000);
        apply("addl_ovf", S_RUN, 1'b0, 3'b100, 6'b000000, 0);
        @(negedge clk); nop(); ex(I_JXX, C_L);    apply("jl", S_RUN, 1'b0, 3'b011, 6'b001100, 1);
        @(negedge clk); nop(); ex(I_JXX, C_G);    apply("jg", S_RUN, 1'b1, 3'b011, 6'b000000, 0);
        @(negedge clk); nop(); alu(ALU_AND, 32'hFFFF_FFFF, 32'h0, 32'h0);
        apply("andl", S_RUN, 1'b0, 3'b011, 6'b000000, 0);
        @(negedge clk); nop(); ex(I_JXX, C_LE);   apply("jle", S_RUN, 1'b1, 3'b100, 6'b000000, 0);
        @(negedge clk); nop(); ex(I_JXX, 4'h7);   apply("jbad", S_RUN, 1'b0, 3'b100, 6'b001100, 1);
        @(negedge clk); nop(); alu(ALU_XOR, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        apply("xorl", S_RUN, 1'b0, 3'b100, 6'b000000, 0);
        @(negedge clk); nop(); alu(ALU_SUB, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF);
        apply("subl_ovf", S_RUN, 1'b0, 3'b010, 6'b000000, 0);
        @(negedge clk); nop(); ex(I_JXX, C_GE);   apply("jge", S_RUN, 1'b0, 3'b001, 6'b001100, 1);
        @(negedge clk); nop(); ex(I_JXX, C_E);    apply("je_nz", S_RUN, 1'b0, 3'b001, 6'b001100, 1);
        // Load-use and ret hazards
        @(negedge clk); nop(); ex(I_MRMOVL, 4'h0); E_dstM = 4'd3; d_srcB = 4'd3;
        apply("load_use", S_RUN, 1'b0, 3'b001, 6'b110100, 0);
        @(negedge clk); nop(); ex(I_MRMOVL, 4'h0); E_dstM = RNONE; d_srcB = 4'd3;
        apply("load_rnone", S_RUN, 1'b0, 3'b001, 6'b000000, 0);
        @(negedge clk); nop(); ex(I_POPL, 4'h0); E_dstM = 4'd5; d_srcA = 4'd5;
        apply("pop_use", S_RUN, 1'b0, 3'b001, 6'b110100, 0);
        @(negedge clk); nop(); D_icode = I_RET;
        apply("ret_d", S_RUN, 1'b0, 3'b001, 6'b101000, 0);
        @(negedge clk); nop(); ex(I_MRMOVL, 4'h0); E_dstM = 4'd2; d_srcA = 4'd2; M_icode = I_RET;
        apply("lu_ret_m", S_RUN, 1'b0, 3'b001, 6'b110100, 0);
        @(negedge clk); nop(); ex(I_RET, 4'h0);
        apply("ret_e", S_RUN, 1'b0, 3'b001, 6'b101000, 0);
        @(negedge clk); nop(); ex(I_JXX, C_E); D_icode = I_RET;
        apply("ret_mispred", S_RUN, 1'b0, 3'b001, 6'b101100, 1);
        // Drive the stall counter into saturation
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); nop(); D_icode = I_RET;
            apply("stall_loop", S_RUN, 1'b0, 3'b001, 6'b101000, 0);
        end
        @(negedge clk); nop(); apply("sat", S_RUN, 1'b0, 3'b001, 6'b000000, 0);
        // Asynchronous reset in the middle of a run
        @(negedge clk); rst = 1'b0; nop();
        tot_cyc = 0; tot_stl = 0; tot_mis = 0; exp_hs = STAT_AOK;
        apply("rst_mid", S_RST, 1'b0, 3'b100, 6'b000000, 0);
        @(negedge clk); rst = 1'b1; nop(); apply("post_rst0", S_RUN, 1'b0, 3'b100, 6'b000000, 0);
        @(negedge clk); nop();                  apply("post_rst1", S_RUN, 1'b0, 3'b100, 6'b000000, 0);
        // Drain then halt
        @(negedge clk); nop(); m_stat = STAT_ADR; alu(ALU_ADD, 32'd0, 32'd0, 32'd1);
        apply("m_adr", S_RUN, 1'b0, 3'b100, 6'b000010, 0);
        @(negedge clk); nop(); alu(ALU_ADD, 32'd0, 32'd0, 32'd1);
        apply("drain_opl", S_DRN, 1'b0, 3'b100, 6'b000000, 0);
        @(negedge clk); nop(); W_stat = STAT_ADR; alu(ALU_ADD, 32'd0, 32'd0, 32'd1);
        apply("w_adr", S_DRN, 1'b0, 3'b100, 6'b000011, 0);
        exp_hs = STAT_ADR;
        @(negedge clk); nop(); ex(I_JXX, C_NE); apply("halt_jne", S_HLT, 1'b0, 3'b100, 6'b110001, 0);
        @(negedge clk); nop(); ex(I_JXX, C_E);  apply("halt_je", S_HLT, 1'b1, 3'b100, 6'b110001, 0);
        @(negedge clk); nop(); alu(ALU_ADD, 32'd0, 32'd0, 32'd1);
        apply("halt_opl", S_HLT, 1'b0, 3'b100, 6'b110001, 0);
        @(negedge clk); nop(); apply("halt_frozen", S_HLT, 1'b0, 3'b100, 6'b110001, 0);
        // Reset out of HALTED, then W_stat priority over m_stat
        @(negedge clk); rst = 1'b0; nop();
        tot_cyc = 0; tot_stl = 0; tot_mis = 0; exp_hs = STAT_AOK;
        apply("rst_halt", S_RST, 1'b0, 3'b100, 6'b000000, 0);
        @(negedge clk); rst = 1'b1; nop(); m_stat = STAT_INS; W_stat = STAT_HLT;
        apply("both_bad", S_RUN, 1'b0, 3'b100, 6'b000011, 0);
        exp_hs = STAT_HLT;
        @(negedge clk); nop(); apply("w_priority", S_HLT, 1'b0, 3'b100, 6'b110001, 0);

        repeat (3) @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
